mem_access_unit: RTL and testbench

//  Sits between the EX/MEM pipeline register and the word-only data memory.

---
 rtl/mem_access_unit.sv | 213 +++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store adapter between the EX/MEM stage and a word-only data memory.
// Sub-word stores take a read cycle plus a write cycle; loads return one cycle after the request.
module mem_access_unit #(
    parameter logic [31:0] DM_START = 32'h0000_0000,
    parameter logic [31:0] DM_END   = 32'h0000_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        load_valid,
    output logic [31:0] load_data,
    output logic        fault,
    output logic [31:0] dm_addr,
    output logic        dm_rw,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata
);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [29:0] waddr_q, waddr_d;
    logic [31:0] merge_q, merge_d;
    logic        load_valid_q, load_valid_d;
    logic [31:0] load_data_q, load_data_d;
    logic        fault_q, fault_d;

    logic        misalign_s;
    logic        below_s;
    logic        above_s;
    logic        fault_s;
    logic [32:0] last_s;

    function automatic logic [32:0] last_byte_addr(input logic [31:0] addr,
                                                   input logic [1:0]  size);
        logic [32:0] span;
        case (size)
            SZ_BYTE: span = 33'd0;
            SZ_HALF: span = 33'd1;
            SZ_WORD: span = 33'd3;
            default: span = 33'd0;
        endcase
        return {1'b0, addr} + span;
    endfunction

    function automatic logic [31:0] merge_lane(input logic [31:0] word,
                                               input logic [31:0] wdata,
                                               input logic [1:0]  size,
                                               input logic [1:0]  offs);
        logic [31:0] res;
        res = word;
        case (size)
            SZ_BYTE: res[{offs, 3'b000} +: 8]        = wdata[7:0];
            SZ_HALF: res[{offs[1], 4'b0000} +: 16]   = wdata[15:0];
            default: res                             = wdata;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] extract_load(input logic [31:0] word,
                                                 input logic [1:0]  size,
                                                 input logic [1:0]  offs,
                                                 input logic        uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[{offs, 3'b000} +: 8];
        h = word[{offs[1], 4'b0000} +: 16];
        case (size)
            SZ_BYTE: res = uns ? {24'd0, b} : {{24{b[7]}}, b};
            SZ_HALF: res = uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

    // Request legality: alignment for the access size and the full byte span inside data memory
    always_comb begin
        misalign_s = 1'b0;
        case (req_size)
            SZ_BYTE: misalign_s = 1'b0;
            SZ_HALF: misalign_s = req_addr[0];
            SZ_WORD: misalign_s = (req_addr[1:0] != 2'b00);
            default: misalign_s = 1'b1;
        endcase
        last_s  = last_byte_addr(req_addr, req_size);
        // borrow out of the 33-bit subtraction flags an address below DM_START
        below_s = 1'(({1'b0, req_addr} - {1'b0, DM_START}) >> 32);
        above_s = (last_s > {1'b0, DM_END});
        fault_s = misalign_s | below_s | above_s;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: only a legal sub-word store leaves IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid && req_write && !fault_s && (req_size != SZ_WORD)) begin
                    state_d = RMW_WR;
                end else begin
                    state_d = IDLE;
                end
            end
            RMW_WR:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Memory-side outputs; writes and stall are suppressed while reset is high
    always_comb begin
        dm_addr  = 32'd0;
        dm_rw    = 1'b0;
        dm_wdata = 32'd0;
        stall    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && !fault_s) begin
                    dm_addr = {req_addr[31:2], 2'b00};
                    if (req_write) begin
                        if (req_size == SZ_WORD) begin
                            dm_rw    = ~reset;
                            dm_wdata = req_wdata;
                        end else begin
                            stall = ~reset;
                        end
                    end else begin
                        dm_rw = 1'b0;
                    end
                end else begin
                    dm_addr = 32'd0;
                end
            end
            RMW_WR: begin
                dm_addr  = {waddr_q, 2'b00};
                dm_rw    = ~reset;
                dm_wdata = merge_q;
            end
            default: begin
                dm_addr = 32'd0;
            end
        endcase
    end

    // Next values for the load result, fault pulse and read-modify-write holding registers
    always_comb begin
        load_valid_d = 1'b0;
        load_data_d  = 32'd0;
        fault_d      = 1'b0;
        merge_d      = merge_q;
        waddr_d      = waddr_q;
        if ((state_q == IDLE) && req_valid) begin
            fault_d = fault_s;
            if (req_write) begin
                if (!fault_s) begin
                    merge_d = merge_lane(dm_rdata, req_wdata, req_size, req_addr[1:0]);
                    waddr_d = req_addr[31:2];
                end else begin
                    merge_d = merge_q;
                end
            end else begin
                load_valid_d = 1'b1;
                load_data_d  = fault_s ? 32'd0
                                       : extract_load(dm_rdata, req_size, req_addr[1:0], req_unsigned);
            end
        end else begin
            fault_d = 1'b0;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            load_valid_q <= 1'b0;
            load_data_q  <= 32'd0;
            fault_q      <= 1'b0;
            merge_q      <= 32'd0;
            waddr_q      <= 30'd0;
        end else begin
            load_valid_q <= load_valid_d;
            load_data_q  <= load_data_d;
            fault_q      <= fault_d;
            merge_q      <= merge_d;
            waddr_q      <= waddr_d;
        end
    end

    assign load_valid = load_valid_q;
    assign load_data  = load_data_q;
    assign fault      = fault_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, reset-during-write sequence,
// and random accesses checked against a byte-addressed memory model.
module tb_mem_access_unit;

    localparam logic [31:0] DM_END = 32'h0000_FFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        stall, load_valid, fault, dm_rw;
    logic [31:0] load_data, dm_addr, dm_wdata, dm_rdata;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .stall(stall), .load_valid(load_valid),
        .load_data(load_data), .fault(fault), .dm_addr(dm_addr), .dm_rw(dm_rw),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
    );

    // Word memory seen by the DUT; writes commit at negedge
    logic [31:0] phys [0:16383];
    logic        pl_en = 1'b0;
    logic [13:0] pl_idx = 14'd0;
    logic [31:0] pl_data = 32'd0;
    always @(negedge clk) begin
        if (pl_en) phys[pl_idx] <= pl_data;
        else if (dm_rw) phys[dm_addr[15:2]] <= dm_wdata;
    end
    assign dm_rdata = phys[dm_addr[15:2]];

    // Reference model: plain byte array
    logic [7:0] bmem [0:65535];

    int n_tests = 0;
    int n_fail  = 0;

    logic        o_stall, o_rw, o_lv, o_f, r_rw, r_stall;
    logic [31:0] o_ld, o_addr, r_wd;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int m_bytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic m_fault(input logic [1:0] sz, input logic [31:0] a);
        longint la;
        longint n;
        la = longint'({32'd0, a});
        n  = longint'(m_bytes(sz));
        if (sz == 2'd3) return 1'b1;
        if ((la % n) != 0) return 1'b1;
        if (la + n - 1 > longint'({32'd0, DM_END})) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] sz, input logic uns, input logic [31:0] a);
        longint v;
        int n;
        n = m_bytes(sz);
        v = 0;
        for (int i = 0; i < n; i++) v = v | (longint'(bmem[a + i]) << (8 * i));
        if (!uns && n < 4 && v[8 * n - 1]) v = v - (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    function automatic logic [31:0] m_word(input logic [31:0] a);
        logic [31:0] b;
        b = {a[31:2], 2'b00};
        return {bmem[b + 3], bmem[b + 2], bmem[b + 1], bmem[b]};
    endfunction

    task automatic m_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        for (int i = 0; i < m_bytes(sz); i++) bmem[a + i] = wd[8 * i +: 8];
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        for (int i = 0; i < 4; i++) bmem[a + i] = d[8 * i +: 8];
        pl_en = 1'b1; pl_idx = a[15:2]; pl_data = d;
        @(negedge clk); #1;
        pl_en = 1'b0;
    endtask

    // Called at posedge+1; returns at posedge+1 after the access retires
    task automatic access(input logic w, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd);
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        #2;
        o_stall = stall; o_rw = dm_rw; o_addr = dm_addr;
        @(posedge clk); #1;
        o_lv = load_valid; o_ld = load_data; o_f = fault;
        r_rw = 1'b0; r_wd = 32'd0; r_stall = 1'b0;
        if (o_stall) begin
            #2;
            r_rw = dm_rw; r_wd = dm_wdata; r_stall = stall;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
    endtask

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        exp_lv;
        logic [31:0] exp_ld;
        logic        exp_f;
        logic        exp_stall;
        logic [31:0] chk_addr;
        logic [31:0] exp_mem;
    } vec_t;

    vec_t tbl [25];

    initial begin
        logic        w, uns, ef, exp_rw;
        logic [1:0]  sz;
        logic [31:0] a, wd, eld;
        int          r;

        tbl[0]  = '{1'b1, 2'd0, 1'b0, 32'h12,       32'hAB,       1'b0, 32'h0,        1'b0, 1'b1, 32'h10,   32'h11AB3344};
        tbl[1]  = '{1'b0, 2'd0, 1'b0, 32'h21,       32'h0,        1'b1, 32'h0000007F, 1'b0, 1'b0, 32'h20,   32'h80FF7F01};
        tbl[2]  = '{1'b0, 2'd0, 1'b0, 32'h22,       32'h0,        1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h20,   32'h80FF7F01};
        tbl[3]  = '{1'b0, 2'd0, 1'b1, 32'h22,       32'h0,        1'b1, 32'h000000FF, 1'b0, 1'b0, 32'h20,   32'h80FF7F01};
        tbl[4]  = '{1'b0, 2'd1, 1'b0, 32'h22,       32'h0,        1'b1, 32'hFFFF80FF, 1'b0, 1'b0, 32'h20,   32'h80FF7F01};
        tbl[5]  = '{1'b0, 2'd1, 1'b1, 32'h22,       32'h0,        1'b1, 32'h000080FF, 1'b0, 1'b0, 32'h20,   32'h80FF7F01};
        tbl[6]  = '{1'b1, 2'd1, 1'b0, 32'h20,       32'h1234BEEF, 1'b0, 32'h0,        1'b0, 1'b1, 32'h20,   32'h80FFBEEF};
        tbl[7]  = '{1'b0, 2'd0, 1'b0, 32'h20,       32'h0,        1'b1, 32'hFFFFFFEF, 1'b0, 1'b0, 32'h20,   32'h80FFBEEF};
        tbl[8]  = '{1'b1, 2'd2, 1'b0, 32'h31,       32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 32'h30,   32'hCAFEF00D};
        tbl[9]  = '{1'b0, 2'd1, 1'b0, 32'h33,       32'h0,        1'b1, 32'h0,        1'b1, 1'b0, 32'h30,   32'hCAFEF00D};
        tbl[10] = '{1'b1, 2'd0, 1'b0, 32'h40,       32'h55,       1'b0, 32'h0,        1'b0, 1'b1, 32'h40,   32'h01020355};
        tbl[11] = '{1'b0, 2'd2, 1'b0, 32'h40,       32'h0,        1'b1, 32'h01020355, 1'b0, 1'b0, 32'h40,   32'h01020355};
        tbl[12] = '{1'b1, 2'd2, 1'b0, 32'h10000,    32'hFFFFFFFF, 1'b0, 32'h0,        1'b1, 1'b0, 32'hFFFC, 32'hDEADBEEF};
        tbl[13] = '{1'b0, 2'd1, 1'b0, 32'hFFFF,     32'h0,        1'b1, 32'h0,        1'b1, 1'b0, 32'hFFFC, 32'hDEADBEEF};
        tbl[14] = '{1'b0, 2'd2, 1'b0, 32'hFFFC,     32'h0,        1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 32'hFFFC, 32'hDEADBEEF};
        tbl[15] = '{1'b1, 2'd0, 1'b0, 32'hFFFF,     32'h77,       1'b0, 32'h0,        1'b0, 1'b1, 32'hFFFC, 32'h77ADBEEF};
        tbl[16] = '{1'b0, 2'd1, 1'b0, 32'hFFFE,     32'h0,        1'b1, 32'h000077AD, 1'b0, 1'b0, 32'hFFFC, 32'h77ADBEEF};
        tbl[17] = '{1'b0, 2'd3, 1'b0, 32'h10,       32'h0,        1'b1, 32'h0,        1'b1, 1'b0, 32'h10,   32'h11AB3344};
        tbl[18] = '{1'b1, 2'd2, 1'b0, 32'h30,       32'h12345678, 1'b0, 32'h0,        1'b0, 1'b0, 32'h30,   32'h12345678};
        tbl[19] = '{1'b0, 2'd0, 1'b1, 32'hFFFFFFFF, 32'h0,        1'b1, 32'h0,        1'b1, 1'b0, 32'h30,   32'h12345678};
        tbl[20] = '{1'b1, 2'd1, 1'b0, 32'h12,       32'h9999,     1'b0, 32'h0,        1'b0, 1'b1, 32'h10,   32'h99993344};
        tbl[21] = '{1'b0, 2'd0, 1'b0, 32'h13,       32'h0,        1'b1, 32'hFFFFFF99, 1'b0, 1'b0, 32'h10,   32'h99993344};
        tbl[22] = '{1'b0, 2'd2, 1'b0, 32'hFFFE,     32'h0,        1'b1, 32'h0,        1'b1, 1'b0, 32'hFFFC, 32'h77ADBEEF};
        tbl[23] = '{1'b1, 2'd1, 1'b0, 32'hFFFE,     32'h1234,     1'b0, 32'h0,        1'b0, 1'b1, 32'hFFFC, 32'h1234BEEF};
        tbl[24] = '{1'b0, 2'd2, 1'b1, 32'hFFFC,     32'h0,        1'b1, 32'h1234BEEF, 1'b0, 1'b0, 32'hFFFC, 32'h1234BEEF};

        // Preload while reset is held
        preload(32'h10, 32'h11223344);
        preload(32'h20, 32'h80FF7F01);
        preload(32'h30, 32'hCAFEF00D);
        preload(32'h40, 32'h01020304);
        preload(32'h50, 32'hA5A5A5A5);
        for (int i = 0; i < 16; i++) preload(32'h100 + 32'(4 * i), $urandom);
        for (int i = 0; i < 3; i++) preload(32'hFFF0 + 32'(4 * i), $urandom);
        preload(32'hFFFC, 32'hDEADBEEF);
        @(posedge clk); #1;
        check("rst_load_valid", 32'(load_valid), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_load_data", load_data, 32'd0);
        check("rst_dm_rw", 32'(dm_rw), 32'd0);
        reset = 1'b0;

        // Directed table
        for (int i = 0; i < 25; i++) begin
            access(tbl[i].w, tbl[i].sz, tbl[i].uns, tbl[i].addr, tbl[i].wd);
            exp_rw = tbl[i].w && !tbl[i].exp_f && (tbl[i].sz == 2'd2);
            check($sformatf("tbl%0d_stall", i), 32'(o_stall), 32'(tbl[i].exp_stall));
            check($sformatf("tbl%0d_rw", i), 32'(o_rw), 32'(exp_rw));
            check($sformatf("tbl%0d_lv", i), 32'(o_lv), 32'(tbl[i].exp_lv));
            check($sformatf("tbl%0d_ld", i), o_ld, tbl[i].exp_ld);
            check($sformatf("tbl%0d_fault", i), 32'(o_f), 32'(tbl[i].exp_f));
            if (!tbl[i].exp_f)
                check($sformatf("tbl%0d_addr", i), o_addr, tbl[i].addr & 32'hFFFF_FFFC);
            if (tbl[i].exp_stall) begin
                check($sformatf("tbl%0d_rmw_rw", i), 32'(r_rw), 32'd1);
                check($sformatf("tbl%0d_rmw_wd", i), r_wd, tbl[i].exp_mem);
                check($sformatf("tbl%0d_rmw_stall", i), 32'(r_stall), 32'd0);
            end
            check($sformatf("tbl%0d_mem", i), phys[tbl[i].chk_addr[15:2]], tbl[i].exp_mem);
            if (tbl[i].w && !tbl[i].exp_f) m_store(tbl[i].sz, tbl[i].addr, tbl[i].wd);
        end

        // Reset arriving in the write cycle of a sub-word store drops the write
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h51; req_wdata = 32'h3C;
        #2;
        check("rstrmw_stall", 32'(stall), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        #2;
        check("rstrmw_rw", 32'(dm_rw), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0; req_valid = 1'b0;
        check("rstrmw_lv", 32'(load_valid), 32'd0);
        check("rstrmw_fault", 32'(fault), 32'd0);
        check("rstrmw_mem", phys[14'h14], 32'hA5A5A5A5);
        access(1'b0, 2'd2, 1'b0, 32'h50, 32'd0);
        check("rstrmw_idle_stall", 32'(o_stall), 32'd0);
        check("rstrmw_ld", o_ld, 32'hA5A5A5A5);
        check("rstrmw_ld_valid", 32'(o_lv), 32'd1);

        // Random accesses against the byte model
        for (int k = 0; k < 400; k++) begin
            r = $urandom_range(0, 9);
            if (r < 7)      a = 32'h100 + 32'($urandom_range(0, 63));
            else if (r < 9) a = 32'hFFF0 + 32'($urandom_range(0, 19));
            else            a = $urandom;
            sz  = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            w   = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            wd  = $urandom;
            ef  = m_fault(sz, a);
            eld = (!w && !ef) ? m_load(sz, uns, a) : 32'd0;
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
            access(w, sz, uns, a, wd);
            check($sformatf("rnd%0d_stall", k), 32'(o_stall), 32'(w && !ef && sz != 2'd2));
            check($sformatf("rnd%0d_rw", k), 32'(o_rw), 32'(w && !ef && sz == 2'd2));
            check($sformatf("rnd%0d_fault", k), 32'(o_f), 32'(ef));
            check($sformatf("rnd%0d_lv", k), 32'(o_lv), 32'(!w));
            check($sformatf("rnd%0d_ld", k), o_ld, eld);
            if (w && !ef) begin
                m_store(sz, a, wd);
                if (sz != 2'd2) begin
                    check($sformatf("rnd%0d_rmw_rw", k), 32'(r_rw), 32'd1);
                    check($sformatf("rnd%0d_rmw_wd", k), r_wd, m_word(a));
                end
            end
        end

        // Final memory image of the exercised windows
        for (int i = 0; i < 16; i++)
            check($sformatf("final_mem_%0h", 32'h100 + 4 * i), phys[14'h40 + 14'(i)], m_word(32'h100 + 32'(4 * i)));
        for (int i = 0; i < 4; i++)
            check($sformatf("final_mem_%0h", 32'hFFF0 + 4 * i), phys[14'h3FFC + 14'(i)], m_word(32'hFFF0 + 32'(4 * i)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
